// File: rtl/if_id_pkg.sv
// Shared pipeline definitions: fetch FSM states, the NOP encoding and the default reset PC.
// ID/EX and later stages import this for NOP insertion and reset PC.
package if_id_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2
   } fetch_state_e;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/if_id_pc.sv
// Program counter with +4 incrementer and next-pc select (redirect / advance / hold).
// The increment wraps modulo 2^32.
module pc_unit
   import if_id_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        advance,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4
);

   logic [31:0] pc_next;

   assign pc_plus4 = pc + 32'd4;

   always_comb begin
      pc_next = pc;
      if (redirect)
         pc_next = word_align(redirect_pc);
      else if (advance)
         pc_next = pc_plus4;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         pc <= RESET_PC;
      else
         pc <= pc_next;
   end

endmodule

// File: rtl/if_id_stage.sv
// Instruction fetch with request/ready handshake, stall hold buffer and the IF/ID register.
// Redirect from EX overrides stall and discards any in-flight or buffered word.
module if_id_stage
   import if_id_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter logic [31:0] NOP      = NOP_INSTR
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   output logic [31:0] IF_ID_pc_add_out,
   output logic [31:0] IF_ID_instr,
   output logic        IF_ID_valid
);

   fetch_state_e state_q, state_d;

   logic [31:0] pc, pc_plus4;
   logic        pc_redirect, pc_advance;
   logic        ld_fetch, ld_bubble, ld_hold, ld_buf, clr_buf;

   logic [31:0] buf_pc_p0, buf_instr_p0;
   logic [31:0] if_id_pc_p1, if_id_instr_p1;
   logic        vld_p1;

   pc_unit #(.RESET_PC(RESET_PC)) u_pc (
      .clock       (clock),
      .reset       (reset),
      .redirect    (pc_redirect),
      .redirect_pc (redirect_pc),
      .advance     (pc_advance),
      .pc          (pc),
      .pc_plus4    (pc_plus4)
   );

   // Address comes straight from the pc register, never from redirect_pc.
   assign imem_addr = pc;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      imem_req    = 1'b0;
      pc_redirect = 1'b0;
      pc_advance  = 1'b0;
      ld_fetch    = 1'b0;
      ld_bubble   = 1'b0;
      ld_hold     = 1'b0;
      ld_buf      = 1'b0;
      clr_buf     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            state_d = ST_FETCH;
         end
         ST_FETCH: begin
            imem_req = 1'b1;
            if (redirect) begin
               pc_redirect = 1'b1;
               ld_bubble   = 1'b1;
               clr_buf     = 1'b1;
            end else if (!stall) begin
               if (imem_ready) begin
                  ld_fetch   = 1'b1;
                  pc_advance = 1'b1;
               end else begin
                  ld_bubble  = 1'b1;
               end
            end else if (imem_ready) begin
               ld_buf  = 1'b1;
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (redirect) begin
               pc_redirect = 1'b1;
               ld_bubble   = 1'b1;
               clr_buf     = 1'b1;
               state_d     = ST_FETCH;
            end else if (!stall) begin
               ld_hold    = 1'b1;
               pc_advance = 1'b1;
               state_d    = ST_FETCH;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Stage p0: word returned while stalled is parked until the stall clears.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         buf_pc_p0    <= '0;
         buf_instr_p0 <= '0;
      end else if (clr_buf) begin
         buf_pc_p0    <= '0;
         buf_instr_p0 <= '0;
      end else if (ld_buf) begin
         buf_pc_p0    <= pc_plus4;
         buf_instr_p0 <= imem_rdata;
      end
   end

   // Stage p1: IF/ID register; a bubble keeps the previous pc+4 value.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         if_id_pc_p1    <= '0;
         if_id_instr_p1 <= NOP;
         vld_p1         <= 1'b0;
      end else if (ld_bubble) begin
         if_id_instr_p1 <= NOP;
         vld_p1         <= 1'b0;
      end else if (ld_fetch) begin
         if_id_pc_p1    <= pc_plus4;
         if_id_instr_p1 <= imem_rdata;
         vld_p1         <= 1'b1;
      end else if (ld_hold) begin
         if_id_pc_p1    <= buf_pc_p0;
         if_id_instr_p1 <= buf_instr_p0;
         vld_p1         <= 1'b1;
      end
   end

   assign IF_ID_pc_add_out = if_id_pc_p1;
   assign IF_ID_instr      = if_id_instr_p1;
   assign IF_ID_valid      = vld_p1;

endmodule

// File: doc/if_id_stage.md
# if_id_stage

Instruction-fetch stage plus IF/ID pipeline register for the multistage MIPS datapath. It owns the PC, fetches from instruction memory over a request/ready handshake, and presents `IF_ID_pc_add_out`/`IF_ID_instr` to decode, which feeds the ID/EX register. It honours stall from the hazard unit and redirect (taken branch, J/JAL, JR) from EX, and holds a fetched word that arrives during a stall.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_3000. PC value loaded on reset.
- `NOP`, default 32'h0000_0000. Instruction word inserted on bubble or flush.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low.
- `stall`  in  1  hazard unit; hold PC and IF/ID.
- `redirect`  in  1  EX: control transfer taken this cycle.
- `redirect_pc`  in  32  EX: target address; bits [1:0] ignored.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address, always word aligned.
- `imem_rdata`  in  32  instruction word, valid when `imem_ready`=1.
- `imem_ready`  in  1  same-cycle response to `imem_req`.
- `IF_ID_pc_add_out`  out  32  PC+4 of the held instruction.
- `IF_ID_instr`  out  32  held instruction.
- `IF_ID_valid`  out  1  1 = real instruction, 0 = bubble.

## Operation
- States: IDLE, FETCH, HOLD. Reset enters IDLE. IDLE -> FETCH unconditionally after one cycle.
- FETCH:
  - `imem_req`=1, `imem_addr`=pc.
  - ready and not stall: IF_ID <= {pc+4, rdata, 1}; pc <= pc+4.
  - not ready and not stall: IF_ID_valid <= 0, IF_ID_instr <= NOP, `IF_ID_pc_add_out` unchanged; pc unchanged.
  - ready and stall: buffer {pc+4, rdata}; IF_ID unchanged; go to HOLD.
  - stall without ready: everything unchanged.
- HOLD:
  - `imem_req`=0.
  - While stall: nothing changes.
  - When stall drops: IF_ID <= buffer with valid=1; pc <= pc+4; go to FETCH.
- Redirect has priority over everything, in any state except IDLE, regardless of stall:
  - pc <= {redirect_pc[31:2],2'b00}.
  - IF_ID_valid <= 0, IF_ID_instr <= NOP.
  - Any response in the same cycle and the HOLD buffer are discarded.
  - Next state FETCH.
- Redirect in IDLE is ignored.
- Arithmetic: pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0 with no flag.

## Timing
- Reset values:
  - pc = RESET_PC; state IDLE.
  - `imem_req`=0; `imem_addr`=RESET_PC.
  - `IF_ID_pc_add_out`=0, `IF_ID_instr`=NOP, `IF_ID_valid`=0.
  - Buffer = 0.
- Reset asserted mid-operation clears everything immediately (asynchronous), including the HOLD buffer.
- Latency: with ready=1 and no stall, the first instruction appears in IF/ID after the second rising edge following reset release. Throughput is then one instruction per cycle.
- Redirect asserted in cycle N: bubble in IF/ID after edge N; target instruction in IF/ID after edge N+1 if ready.
- `imem_addr` is driven from pc only (registered), with no combinational path from `redirect_pc`.

## Structure
- Shared pipeline package holds the state enum (IDLE/FETCH/HOLD), the `NOP` encoding and the default `RESET_PC`; ID/EX and later stages reuse NOP and the reset PC.
- One sub-module, `pc_unit`: pc register, +4 adder and next-pc mux (redirect / +4 / hold).
- FSM, hold buffer and IF/ID registers live in the top.

## Test plan
- Reset release with ready=1 and memory word = address: IF/ID shows {0x3004,0x3000,1}, then {0x3008,0x3004,1}, one per cycle.
- ready low for 3 cycles at pc 0x3008: three bubbles (valid=0, instr NOP), `imem_addr` stays 0x3008, then {0x300C,0x3008,1}.
- stall asserted in the same cycle as ready at 0x3010: IF/ID frozen, FSM in HOLD with `imem_req`=0 for 4 cycles; after stall drops, IF/ID={0x3014,word@0x3010,1}, then `imem_addr`=0x3014.
- redirect=1 with redirect_pc=0x3043 while in HOLD and stall=1: buffer dropped, IF/ID bubble, `imem_addr`=0x3040 next cycle, then {0x3044,word@0x3040,1}.
- redirect to 0xFFFF_FFFC followed by a fetch: IF_ID_pc_add_out=0 and next `imem_addr`=0.
- reset asserted in mid-FETCH and again in HOLD: all outputs take their reset values without a clock edge; fetch restarts at 0x3000.
